// File: rtl/div_star_if.sv
// Operand/result handshake bundle for div_star: operands in on a valid/ready pair,
// quotient, remainder and divide-by-zero flag out on a second valid/ready pair.
interface div_star_if #(
  parameter int unsigned BITLEN = 17
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2*BITLEN-1:0]   N;
  logic [BITLEN-1:0]     D;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*BITLEN-1:0]   Q;
  logic [BITLEN-1:0]     R;
  logic                  dbz;

  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R, dbz
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R, dbz
  );
endinterface

// File: rtl/div_star.sv
// Sequential unsigned radix-4 restoring divider: 2*BITLEN-bit dividend by BITLEN-bit
// divisor, one 2-bit quotient digit per clock, one operation in flight.
module div_star #(
  parameter int unsigned BITLEN = 17
) (
  input  logic        clk,
  input  logic        reset,
  div_star_if.slave   bus
);

  localparam int unsigned W2 = 2 * BITLEN;
  localparam int unsigned WT = BITLEN + 2;
  localparam int unsigned CW = (BITLEN > 2) ? $clog2(BITLEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              step;
  logic              last;

  logic [CW-1:0]     cnt;
  logic [W2-1:0]     s;
  logic [BITLEN-1:0] p;
  logic [WT-1:0]     d1;
  logic [WT-1:0]     d2;
  logic [WT-1:0]     d3;
  logic [BITLEN-1:0] n_lo;
  logic              dbz_r;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [W2-1:0]     q_r;
  logic [BITLEN-1:0] r_r;
  logic              dbz_o;

  logic [WT-1:0]     t;
  logic [WT-1:0]     sub;
  logic [WT-1:0]     rem;
  logic [1:0]        digit;
  logic [W2-1:0]     s_shift;

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        step = 1'b1;
        if (cnt == '0) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Digit selection: largest k in 0..3 with k*D <= t, from three parallel compares
  always_comb begin
    t     = {p, s[W2-1 -: 2]};
    digit = 2'd0;
    sub   = '0;
    if (t >= d3) begin
      digit = 2'd3;
      sub   = d3;
    end else if (t >= d2) begin
      digit = 2'd2;
      sub   = d2;
    end else if (t >= d1) begin
      digit = 2'd1;
      sub   = d1;
    end
    rem     = t - sub;
    s_shift = {s[W2-3:0], digit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cnt         <= '0;
      s           <= '0;
      p           <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      n_lo        <= '0;
      dbz_r       <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
      dbz_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= (state_nxt == S_IDLE);
      out_valid_r <= (state_nxt == S_DONE);
      if (accept) begin
        s     <= bus.N;
        p     <= '0;
        d1    <= WT'(bus.D);
        d2    <= WT'(bus.D) << 1;
        d3    <= WT'(bus.D) + (WT'(bus.D) << 1);
        n_lo  <= bus.N[BITLEN-1:0];
        dbz_r <= (bus.D == '0);
        cnt   <= CW'(BITLEN - 1);
      end
      if (step) begin
        s <= s_shift;
        p <= rem[BITLEN-1:0];
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
      // Divide-by-zero overrides the datapath result on entry to DONE
      if (last) begin
        q_r   <= dbz_r ? '1 : s_shift;
        r_r   <= dbz_r ? n_lo : rem[BITLEN-1:0];
        dbz_o <= dbz_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Q         = q_r;
  assign bus.R         = r_r;
  assign bus.dbz       = dbz_o;

endmodule
